// File: rtl/fixed_pkg.sv
// Shared Q-format constants, FSM encoding and the Q56.8 -> Q8.8 saturating helper
// used by the MAC and the downstream clamp stage.
package fixed_pkg;

    localparam int Q8_8_W   = 16;
    localparam int Q16_16_W = 32;
    localparam int Q56_8_W  = 64;
    localparam int FRAC_BITS = 8;
    localparam int CNT_W    = 8;

    localparam logic [Q8_8_W-1:0] Q8_8_MAX = 16'h7FFF;
    localparam logic [Q8_8_W-1:0] Q8_8_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } mac_state_e;

    // Both formats share the same binary point, so saturation is a pure range check.
    function automatic logic [Q8_8_W-1:0] clamp_q56_8(input logic [Q56_8_W-1:0] v);
        logic signed [Q56_8_W-1:0] s;
        s = signed'(v);
        if (s > 64'sd32767) begin
            return Q8_8_MAX;
        end else if (s < -64'sd32768) begin
            return Q8_8_MIN;
        end else begin
            return v[Q8_8_W-1:0];
        end
    endfunction

    function automatic logic clamp_overflows(input logic [Q56_8_W-1:0] v);
        logic signed [Q56_8_W-1:0] s;
        s = signed'(v);
        return (s > 64'sd32767) || (s < -64'sd32768);
    endfunction

endpackage

// File: rtl/fixed_16_mul.sv
// Combinational Q8.8 x Q8.8 -> Q16.16 multiply, reduced to a sign-extended Q56.8 term.
// Define FIXED_MAC_ROUND_EN for round-half-up per term; otherwise the term is floored.
module fixed_16_mul
    import fixed_pkg::*;
#(
    parameter int FRAC = fixed_pkg::FRAC_BITS
) (
    input  logic [Q8_8_W-1:0]  a_i,
    input  logic [Q8_8_W-1:0]  b_i,
    output logic [Q56_8_W-1:0] term_o
);

    logic signed [Q16_16_W-1:0] prod;
    logic signed [Q16_16_W-1:0] biased;
    logic signed [Q16_16_W-1:0] shifted;

    assign prod = 32'($signed(a_i)) * 32'($signed(b_i));

`ifdef FIXED_MAC_ROUND_EN
    // Largest product is 2^30, so adding half an LSB cannot overflow 32 bits.
    localparam logic signed [Q16_16_W-1:0] HALF_LSB = 32'sd1 <<< (FRAC - 1);
    assign biased = prod + HALF_LSB;
`else
    assign biased = prod;
`endif

    assign shifted = biased >>> FRAC;
    assign term_o  = 64'(shifted);

endmodule

// File: rtl/fixed_mac_accum.sv
// Sequential dot-product MAC: N_TERMS signed Q8.8 pairs in, one Q56.8 sum out.
// Term rounding is selected by FIXED_MAC_ROUND_EN (see fixed_16_mul).
module fixed_mac_accum
    import fixed_pkg::*;
#(
    parameter int N_TERMS   = 4,
    parameter int FRAC_BITS = fixed_pkg::FRAC_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [Q8_8_W-1:0]   in_a,
    input  logic [Q8_8_W-1:0]   in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [Q56_8_W-1:0]  out_data,
    output logic                busy
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    mac_state_e         state_q;
    logic [Q56_8_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   count_q;
    logic               in_ready_q, out_valid_q, busy_q;
    logic [Q56_8_W-1:0] term;
    logic               in_xfer, out_xfer;

    fixed_16_mul #(
        .FRAC (FRAC_BITS)
    ) u_mul (
        .a_i    (in_a),
        .b_i    (in_b),
        .term_o (term)
    );

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    // The first term of a dot product loads the accumulator instead of adding to it.
    always_comb begin
        acc_d = acc_q + term;
        if (state_q == IDLE) begin
            acc_d = term;
        end
    end

    // NOTE: every register here uses non-blocking assignment so all state advances
    // together on the edge; the async clear returns the outputs to idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_xfer) begin
                        acc_q   <= acc_d;
                        count_q <= CNT_W'(1);
                        busy_q  <= 1'b1;
                        if (N_TERMS == 1) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_xfer) begin
                        acc_q   <= acc_d;
                        count_q <= count_q + CNT_W'(1);
                        if (count_q == LAST_CNT) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_xfer) begin
                        state_q     <= IDLE;
                        acc_q       <= '0;
                        count_q     <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    acc_q       <= '0;
                    count_q     <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fixed_mac_accum.sv
// Directed bench for fixed_mac_accum (N_TERMS=4) with an expected-result queue.
module tb_fixed_mac_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    fixed_mac_accum #(.N_TERMS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] model_term(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        logic signed [63:0] t;
        p = 32'($signed(a)) * 32'($signed(b));
`ifdef FIXED_MAC_ROUND_EN
        p = p + 32'sd128;
`endif
        t = 64'(p >>> 8);
        return t;
    endfunction

    // Holds one pair valid until it is accepted; returns at posedge+1 of the transfer.
    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_b("in_ready_wait", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = 16'hDEAD;
        in_b = 16'hBEEF;
    endtask

    task automatic run_dot(input logic [15:0] av[4], input logic [15:0] bv[4], input int gap_max);
        logic [63:0] sum;
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            sum = sum + model_term(av[i], bv[i]);
            if (i == 3) check_b("valid_before_last", out_valid, 1'b0);
            send(av[i], bv[i]);
            if (i < 3) check_b("busy_mid", busy, 1'b1);
            if (i < 3 && gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        exp_q.push_back(sum);
        check_b("latency_out_valid", out_valid, 1'b1);
        check_b("done_in_ready", in_ready, 1'b0);
        check_b("done_busy", busy, 1'b1);
    endtask

    task automatic run_same(input logic [15:0] a, input logic [15:0] b, input int gap_max);
        logic [15:0] av[4];
        logic [15:0] bv[4];
        for (int i = 0; i < 4; i++) begin
            av[i] = a;
            bv[i] = b;
        end
        run_dot(av, bv, gap_max);
    endtask

    // Stalls the output for `hold` cycles while offering junk input, then accepts it.
    task automatic collect(input int hold, output logic [63:0] got);
        logic [63:0] first;
        logic [63:0] expv;
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_b("out_valid_wait", out_valid, 1'b1);
        @(negedge clk);
        first = out_data;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            @(negedge clk);
            check("hold_data_stable", out_data, first);
            check_b("hold_in_ready", in_ready, 1'b0);
            check_b("hold_out_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
        check("result", out_data, expv);
        got = out_data;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_b("post_out_valid", out_valid, 1'b0);
        check_b("post_busy", busy, 1'b0);
        check_b("post_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [63:0] got;
        logic [15:0] av[4];
        logic [15:0] bv[4];

        // Reset values while held in reset
        repeat (2) @(posedge clk);
        #1;
        check_b("rst_in_ready", in_ready, 1'b1);
        check_b("rst_out_valid", out_valid, 1'b0);
        check_b("rst_busy", busy, 1'b0);
        check("rst_out_data", out_data, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1. positive sum, output taken immediately
        run_same(16'h0100, 16'h0200, 0);
        collect(0, got);
        check("t1_sum_8p0", got, 64'h800);

        // 2. negative sum
        run_same(16'hFE80, 16'h0200, 0);
        collect(0, got);
        check("t2_sum_m12p0", got, 64'hFFFF_FFFF_FFFF_F400);

        // 3. rounding of sub-LSB products
        run_same(16'h0001, 16'h0080, 0);
        collect(0, got);
`ifdef FIXED_MAC_ROUND_EN
        check("t3_round", got, 64'h4);
`else
        check("t3_trunc", got, 64'h0);
`endif

        // 4. extreme operands; downstream clamp saturates
        run_same(16'h8000, 16'h8000, 0);
        collect(0, got);
        check("t4_extreme", got, 64'h100_0000);
        check("t4_clamp", 64'(fixed_pkg::clamp_q56_8(got)), 64'h7FFF);

        // 5. bubbles and output backpressure, then a second dot product
        av = '{16'h0180, 16'hFF00, 16'h0040, 16'h7FFF};
        bv = '{16'h0300, 16'h0280, 16'hFFC0, 16'h0101};
        run_dot(av, bv, 3);
        collect(5, got);
        av = '{16'hFFFF, 16'h1234, 16'h8001, 16'h00FF};
        bv = '{16'h0001, 16'hFEDC, 16'h7FFF, 16'hFF01};
        run_dot(av, bv, 2);
        collect(0, got);

        // 6a. reset after two terms
        send(16'h0500, 16'h0500);
        send(16'h0500, 16'h0500);
        rst_n = 1'b0;
        #1;
        check_b("rst_mid_out_valid", out_valid, 1'b0);
        check_b("rst_mid_busy", busy, 1'b0);
        check_b("rst_mid_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_same(16'h0100, 16'h0300, 0);
        collect(0, got);
        check("t6_fresh_sum", got, 64'hC00);

        // 6b. reset while the result is waiting
        run_same(16'h0200, 16'h0200, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_b("rst_done_out_valid", out_valid, 1'b0);
        check("rst_done_out_data", out_data, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // A few random dot products with bubbles
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                av[i] = 16'($urandom);
                bv[i] = 16'($urandom);
            end
            run_dot(av, bv, 2);
            collect(k, got);
        end

        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
